// File: rtl/stage0_pkg.sv
// Shared types and opcode-field definitions for the axis_cpu fetch stage.
package stage0_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } state_e;

  localparam int unsigned InstrWidth = 64;
  localparam int unsigned OpcodeLsb  = 48;
  localparam int unsigned CntWidth   = 6;
  localparam logic [2:0]  ClassRet   = 3'b110;

  function automatic logic is_ret(input logic [InstrWidth-1:0] instr);
    return instr[OpcodeLsb +: 3] == ClassRet;
  endfunction

endpackage

// File: rtl/stage0_fetch_buf.sv
// Small FIFO of fetched {instr, pc, wait count}; each entry counts its own queued cycles.
module stage0_fetch_buf
  import stage0_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic                           flush,
  input  logic                           cnt_en,
  input  logic [InstrWidth-1:0]          push_instr,
  input  logic [PC_WIDTH-1:0]            push_pc,
  output logic [InstrWidth-1:0]          head_instr,
  output logic [PC_WIDTH-1:0]            head_pc,
  output logic [CntWidth-1:0]            head_cnt,
  output logic                           empty,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(BUF_DEPTH - 1);

  logic [InstrWidth-1:0] instr_q [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   pc_q    [BUF_DEPTH];
  logic [CntWidth-1:0]   cnt_q   [BUF_DEPTH];
  logic [PtrW-1:0]       rd_ptr_q, wr_ptr_q;
  logic [OccW-1:0]       occ_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      // Free-running per-entry counters; a write below restarts its entry at zero.
      for (int i = 0; i < BUF_DEPTH; i++) begin
        if (cnt_en && (cnt_q[i] != '1)) cnt_q[i] <= cnt_q[i] + CntWidth'(1);
      end
      if (flush) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        if (push) begin
          instr_q[wr_ptr_q] <= push_instr;
          pc_q[wr_ptr_q]    <= push_pc;
          cnt_q[wr_ptr_q]   <= '0;
          wr_ptr_q          <= ptr_inc(wr_ptr_q);
        end
        if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
        case ({push, pop})
          2'b10:   occ_q <= occ_q + OccW'(1);
          2'b01:   occ_q <= occ_q - OccW'(1);
          default: ;
        endcase
      end
    end
  end

  assign empty      = (occ_q == '0);
  assign occupancy  = occ_q;
  assign head_instr = instr_q[rd_ptr_q];
  assign head_pc    = pc_q[rd_ptr_q];
  assign head_cnt   = empty ? '0 : cnt_q[rd_ptr_q];

endmodule

// File: rtl/stage0.sv
// axis_cpu fetch stage: PC, not-taken prediction, 1-cycle imem reads, redirect on mispredict.
// Optional STAGE0_PERF_CNT_EN adds fetch_cnt/flush_cnt performance counters.
module stage0
  import stage0_pkg::*;
#(
  parameter int unsigned PC_WIDTH  = 10,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  ret_retired,
  input  logic                  branch_mispredict,
  input  logic [PC_WIDTH-1:0]   branch_target,
  output logic                  inst_rd_en,
  output logic [PC_WIDTH-1:0]   inst_rd_addr,
  input  logic [InstrWidth-1:0] inst_rd_data,
  output logic [InstrWidth-1:0] instr_out,
  output logic [PC_WIDTH-1:0]   pc_out,
  input  logic                  PC_en,
  output logic [CntWidth-1:0]   ocount,
  output logic                  vld,
  input  logic                  next_rdy,
  output logic                  busy
`ifdef STAGE0_PERF_CNT_EN
  ,
  output logic [31:0]           fetch_cnt,
  output logic [31:0]           flush_cnt
`endif
);

  localparam int unsigned OccW = $clog2(BUF_DEPTH + 1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                inflight_q;
  logic                flush, push, pop, ret_land, buf_empty;
  logic [OccW-1:0]     occupancy;
  logic [OccW:0]       demand;

  assign flush    = branch_mispredict || ret_retired;
  assign push     = inflight_q && !flush;
  assign vld      = !buf_empty && !branch_mispredict;
  assign pop      = vld && next_rdy;
  // RET is only recognisable once its data returns; stop issuing in that same cycle.
  assign ret_land = inflight_q && (state_q == StRun) && is_ret(inst_rd_data);
  assign demand   = (OccW+1)'(occupancy) + (OccW+1)'(inflight_q) - (OccW+1)'(pop);

  assign inst_rd_en   = (state_q == StRun) && !flush && !ret_land &&
                        (demand < (OccW+1)'(BUF_DEPTH));
  assign inst_rd_addr = pc_q;
  assign busy         = (state_q != StIdle);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (inst_rd_en) pc_d = pc_q + PC_WIDTH'(1);
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          pc_d    = '0;
        end
      end
      StRun, StDrain: begin
        if (ret_retired) begin
          state_d = StIdle;
        end else if (branch_mispredict) begin
          state_d = StRun;
          pc_d    = branch_target;
        end else if (ret_land) begin
          state_d = StDrain;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      pc_q       <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inst_rd_en;
    end
  end

  // Reads never issue during a flush cycle, so the flush gating on push is the whole kill path.
  stage0_fetch_buf #(
    .PC_WIDTH  (PC_WIDTH),
    .BUF_DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (flush),
    .cnt_en     (PC_en),
    .push_instr (inst_rd_data),
    .push_pc    (pc_q - PC_WIDTH'(1)),
    .head_instr (instr_out),
    .head_pc    (pc_out),
    .head_cnt   (ocount),
    .empty      (buf_empty),
    .occupancy  (occupancy)
  );

`ifdef STAGE0_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (inst_rd_en) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (flush)      flush_cnt_q <= flush_cnt_q + 32'(occupancy) + 32'(inflight_q);
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_stage0.sv
// Scoreboard bench for stage0: expected fetch/delivery streams derived from program memory.
module tb_stage0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, ret_retired, branch_mispredict;
  logic [9:0]  branch_target;
  logic        inst_rd_en;
  logic [9:0]  inst_rd_addr;
  logic [63:0] inst_rd_data;
  logic [63:0] instr_out;
  logic [9:0]  pc_out;
  logic        PC_en;
  logic [5:0]  ocount;
  logic        vld, next_rdy, busy;
`ifdef STAGE0_PERF_CNT_EN
  logic [31:0] fetch_cnt, flush_cnt;
`endif

  stage0 #(
    .PC_WIDTH  (10),
    .BUF_DEPTH (2)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .ret_retired       (ret_retired),
    .branch_mispredict (branch_mispredict),
    .branch_target     (branch_target),
    .inst_rd_en        (inst_rd_en),
    .inst_rd_addr      (inst_rd_addr),
    .inst_rd_data      (inst_rd_data),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .PC_en             (PC_en),
    .ocount            (ocount),
    .vld               (vld),
    .next_rdy          (next_rdy),
    .busy              (busy)
`ifdef STAGE0_PERF_CNT_EN
    ,
    .fetch_cnt         (fetch_cnt),
    .flush_cnt         (flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [63:0] mem [1024];

  always @(posedge clk) begin
    if (inst_rd_en) inst_rd_data <= mem[inst_rd_addr];
  end

  function automatic bit tb_is_ret(input logic [63:0] w);
    return w[50:48] == 3'b110;
  endfunction

  function automatic logic [63:0] make_instr(input bit ret);
    logic [63:0] w;
    logic [2:0]  c;
    w = {$urandom, $urandom};
    if (ret) c = 3'b110;
    else begin
      c = 3'($urandom_range(0, 6));
      if (c == 3'b110) c = 3'b111;
    end
    w[50:48] = c;
    return w;
  endfunction

  // Stimulus -> monitor command channel (each side writes only its own variables).
  int         cmd_seq = 0;
  bit         cmd_clear;
  logic [9:0] cmd_pc;

  int checks = 0, passes = 0;
  int mon_checks = 0, mon_passes = 0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  task automatic issue_cmd(input bit clr, input logic [9:0] pc);
    cmd_clear = clr;
    cmd_pc    = pc;
    cmd_seq++;
  endtask

  // Monitor: expected delivery is the straight-line run from the redirect PC up to its RET.
  logic [9:0] exp_q [$];
  logic [9:0] exp_fetch;
  bit         fetch_done = 1'b1;
  int         seen_seq = 0;

  always @(negedge clk) begin
    logic [9:0] p;
    if (cmd_seq != seen_seq) begin
      seen_seq = cmd_seq;
      exp_q.delete();
      if (cmd_clear) fetch_done = 1'b1;
      else begin
        p = cmd_pc;
        exp_fetch  = cmd_pc;
        fetch_done = 1'b0;
        for (int n = 0; n < 1024; n++) begin
          exp_q.push_back(p);
          if (tb_is_ret(mem[p])) break;
          p = p + 10'd1;
        end
      end
    end
    if (!rst) begin
      if (vld && next_rdy) begin
        mon_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL unexpected_pop: got pc %0h required no output", pc_out);
        end else begin
          p = exp_q.pop_front();
          if (pc_out == p && instr_out == mem[p]) mon_passes++;
          else $display("FAIL pop: got pc %0h instr %0h required pc %0h instr %0h",
                        pc_out, instr_out, p, mem[p]);
        end
      end
      if (inst_rd_en) begin
        mon_checks++;
        if (!fetch_done && inst_rd_addr == exp_fetch) mon_passes++;
        else $display("FAIL fetch_addr: got %0h required %0h (done=%0d)",
                      inst_rd_addr, exp_fetch, fetch_done);
        if (tb_is_ret(mem[inst_rd_addr])) fetch_done = 1'b1;
        exp_fetch = exp_fetch + 10'd1;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      cyc();
      n++;
    end
    check(exp_q.size() == 0, name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    issue_cmd(1'b0, 10'd0);
    cyc();
    start = 1'b0;
  endtask

  task automatic do_mispredict(input logic [9:0] t);
    branch_mispredict = 1'b1;
    branch_target     = t;
    issue_cmd(1'b0, t);
    cyc();
    branch_mispredict = 1'b0;
  endtask

  task automatic do_ret();
    ret_retired = 1'b1;
    next_rdy    = 1'b0;
    issue_cmd(1'b1, 10'd0);
    cyc();
    ret_retired = 1'b0;
    next_rdy    = 1'b1;
    @(negedge clk);
    check(busy == 1'b0, "ret_idle_busy", 64'(busy), 64'd0);
    check(vld == 1'b0, "ret_idle_vld", 64'(vld), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [9:0]  s_pc;
    logic [63:0] s_instr;
    logic [5:0]  s_cnt;
    bit          s_en;
    int          n, quiet, mps;

    rst = 1'b1; start = 1'b0; ret_retired = 1'b0; branch_mispredict = 1'b0;
    branch_target = '0; PC_en = 1'b1; next_rdy = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = make_instr($urandom_range(0, 7) == 0);
    for (int i = 0; i < 4; i++) mem[i] = make_instr(1'b0);
    mem[4] = make_instr(1'b1);
    for (int i = 32'h20; i < 32'h80; i++) mem[i] = make_instr(1'b0);
    mem[10'h80] = make_instr(1'b1);
    mem[1022] = make_instr(1'b0);
    mem[1023] = make_instr(1'b0);

    repeat (2) @(posedge clk);
    #1;
    check(vld == 1'b0, "reset_vld", 64'(vld), 64'd0);
    check(inst_rd_en == 1'b0, "reset_rd_en", 64'(inst_rd_en), 64'd0);
    check(busy == 1'b0, "reset_busy", 64'(busy), 64'd0);
    check(ocount == 6'd0, "reset_ocount", 64'(ocount), 64'd0);
    rst = 1'b0;
    cyc();

    // Short program 0..4 ending in RET, then DRAIN and retire.
    do_start();
    wait_drain(50, "prog_drain");
    repeat (3) cyc();
    check(busy == 1'b1, "drain_busy", 64'(busy), 64'd1);
    do_ret();

    // Mispredict redirect latency, stall behaviour, then redirect out of DRAIN.
    do_start();
    cyc();
    branch_mispredict = 1'b1;
    branch_target     = 10'h20;
    issue_cmd(1'b0, 10'h20);
    @(negedge clk);
    check(vld == 1'b0, "mp_vld_m0", 64'(vld), 64'd0);
    cyc();
    branch_mispredict = 1'b0;
    @(negedge clk);
    check(vld == 1'b0, "mp_vld_m1", 64'(vld), 64'd0);
    cyc();
    @(negedge clk);
    check(vld == 1'b0, "mp_vld_m2", 64'(vld), 64'd0);
    cyc();
    @(negedge clk);
    check(vld == 1'b1 && pc_out == 10'h20, "mp_vld_m3", {pc_out, 3'b0, vld}, {10'h20, 4'b1});
    repeat (3) cyc();
    s_pc = '0; s_instr = '0; s_cnt = '0; s_en = 1'b0;
    for (int k = 0; k < 90; k++) begin
      cyc();
      next_rdy = 1'b0;
      PC_en    = ($urandom_range(0, 7) != 0);
      @(negedge clk);
      if (k > 0) begin
        check(vld == 1'b1 && pc_out == s_pc && instr_out == s_instr, "stall_stable",
              64'(pc_out), 64'(s_pc));
        check(ocount == (s_en ? ((s_cnt == 6'd63) ? 6'd63 : s_cnt + 6'd1) : s_cnt),
              "stall_ocount", 64'(ocount), 64'(s_cnt));
      end
      s_pc = pc_out; s_instr = instr_out; s_cnt = ocount; s_en = PC_en;
    end
    check(inst_rd_en == 1'b0, "stall_no_fetch", 64'(inst_rd_en), 64'd0);
    check(ocount == 6'd63, "stall_saturate", 64'(ocount), 64'd63);
    cyc();
    next_rdy = 1'b1;
    PC_en    = 1'b1;
    wait_drain(300, "stall_drain");
    repeat (3) cyc();
    check(busy == 1'b1, "drain2_busy", 64'(busy), 64'd1);
    do_mispredict(10'd7);
    wait_drain(300, "redirect7_drain");
    do_ret();

    // PC wrap from 1023 back to 0.
    do_start();
    cyc();
    do_mispredict(10'd1022);
    wait_drain(100, "wrap_drain");
    do_ret();

    // Randomised runs: random backpressure, count enable and redirects.
    for (int it = 0; it < 6; it++) begin
      do_start();
      n = 0; quiet = 0; mps = 0;
      while (quiet < 4 && n < 400) begin
        next_rdy = ($urandom_range(0, 3) != 0);
        PC_en    = $urandom_range(0, 1);
        if ($urandom_range(0, 29) == 0 && mps < 3) begin
          branch_mispredict = 1'b1;
          branch_target     = 10'($urandom);
          issue_cmd(1'b0, branch_target);
          mps++;
        end
        cyc();
        branch_mispredict = 1'b0;
        n++;
        quiet = (exp_q.size() == 0) ? quiet + 1 : 0;
      end
      check(n < 400, "rand_budget", 64'(n), 64'd400);
      next_rdy = 1'b1;
      do_ret();
    end

    // Asynchronous reset mid-stream, then a clean restart.
    do_start();
    repeat (4) cyc();
    #2;
    rst = 1'b1;
    #1;
    check(vld == 1'b0, "rst_vld", 64'(vld), 64'd0);
    check(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    check(inst_rd_en == 1'b0, "rst_rd_en", 64'(inst_rd_en), 64'd0);
    issue_cmd(1'b1, 10'd0);
    cyc();
    rst = 1'b0;
    cyc();
    do_start();
    wait_drain(50, "restart_drain");
    do_ret();

    repeat (2) cyc();
    $display("%0d/%0d checks passed", passes + mon_passes, checks + mon_checks);
    $finish;
  end

endmodule
